// File: rtl/ro_multi_freq_meter.sv
// ro_multi_freq_meter
//   Multi-channel ring-oscillator frequency meter. Each measure command turns on
//   one RO channel and waits 2^SETTLE_LOG2 cycles for it to settle. It then counts
//   synchronised rising edges over 2^gate_log2 clk cycles. The count goes out as
//   a big-endian byte stream.
//   Command byte: [7:6]=00 measure channel [5:0]; 01 set gate_log2=[4:0]
//   (clamped to GATE_MAX_LOG2); 1x reserved and ignored.
//   Optional feature: define RO_METER_CHECKSUM_EN to append an XOR trailer byte
//   to every response.
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   osc_in[N_OSC]         raw RO outputs (asynchronous)
//   osc_en[N_OSC]         one-hot RO enable during settle and gate
//   cmd_valid/ready/data  command byte handshake (from UART rx)
//   tx_valid/ready/data   response byte handshake (to UART tx)
//   busy                  high whenever the FSM is not idle
module ro_multi_freq_meter #(
    parameter int N_OSC             = 4,
    parameter int CNT_W             = 24,
    parameter int SYNC_STAGES       = 2,
    parameter int SETTLE_LOG2       = 4,
    parameter int GATE_MAX_LOG2     = 20,
    parameter int DEFAULT_GATE_LOG2 = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_OSC-1:0] osc_in,
    output logic [N_OSC-1:0] osc_en,
    input  logic             cmd_valid,
    input  logic [7:0]       cmd_data,
    output logic             cmd_ready,
    output logic             tx_valid,
    output logic [7:0]       tx_data,
    input  logic             tx_ready,
    output logic             busy
);

    localparam int NB    = (CNT_W + 7) / 8;
    localparam int PAD_W = NB * 8;
    localparam int TMR_W = GATE_MAX_LOG2 + 1;
`ifdef RO_METER_CHECKSUM_EN
    localparam int RESP_N = NB + 1;
`else
    localparam int RESP_N = NB;
`endif

    // DECODE is a one-cycle slot that latches the window and classifies the channel
    typedef enum logic [2:0] {S_IDLE, S_DECODE, S_ENABLE, S_GATE, S_SEND} state_t;

    state_t             state_q, state_d;
    logic [5:0]         ch_q, ch_d;
    logic               bad_ch_q, bad_ch_d;
    logic [4:0]         gate_log2_q, gate_log2_d;
    logic [TMR_W-1:0]   gate_len_q, gate_len_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [N_OSC-1:0]   sync_q [SYNC_STAGES];
    logic [N_OSC-1:0]   sync_d [SYNC_STAGES];
    logic               prev_q, prev_d;
    logic               prev_ok_q, prev_ok_d;
    logic [7:0]         byte_idx_q, byte_idx_d;
    logic               tx_valid_q, tx_valid_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic [N_OSC-1:0]   osc_en_q, osc_en_d;
    logic               busy_q, busy_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic [N_OSC-1:0]   ch_onehot_s;
    logic               sync_lvl_s;
    logic               osc_rise_s;
    logic               bad_ch_s;

    // Data byte idx of the response, MSB first; top byte zero-padded, all 0xFF for a bad channel
    function automatic logic [7:0] resp_byte(input logic [7:0] idx, input logic [CNT_W-1:0] cnt,
                                             input logic bad);
        logic [PAD_W-1:0] padded;
        logic [7:0]       b;
        padded = '0;
        padded[CNT_W-1:0] = cnt;
        b = 8'h00;
        for (int i = 0; i < NB; i++) begin
            if (idx == 8'(i)) b = padded[(NB-1-i)*8 +: 8];
        end
        if (bad) b = 8'hFF;
        return b;
    endfunction

`ifdef RO_METER_CHECKSUM_EN
    // XOR of all NB data bytes
    function automatic logic [7:0] resp_checksum(input logic [CNT_W-1:0] cnt, input logic bad);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < NB; i++) x = x ^ resp_byte(8'(i), cnt, bad);
        return x;
    endfunction
`endif

    // Byte idx of the full response stream (data bytes, then the optional trailer)
    function automatic logic [7:0] stream_byte(input logic [7:0] idx, input logic [CNT_W-1:0] cnt,
                                               input logic bad);
`ifdef RO_METER_CHECKSUM_EN
        if (idx == 8'(NB)) return resp_checksum(cnt, bad);
`endif
        return resp_byte(idx, cnt, bad);
    endfunction

    // Channel decode: one-hot enable pattern and out-of-range detection
    always_comb begin
        ch_onehot_s = '0;
        for (int i = 0; i < N_OSC; i++) begin
            if (ch_q == 6'(i)) ch_onehot_s[i] = 1'b1;
            else               ch_onehot_s[i] = 1'b0;
        end
        bad_ch_s = (int'({26'd0, ch_q}) >= N_OSC);
    end

    // Next-state, counters and registered-output computation
    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        bad_ch_d    = bad_ch_q;
        gate_log2_d = gate_log2_q;
        gate_len_d  = gate_len_q;
        timer_d     = timer_q;
        count_d     = count_q;
        byte_idx_d  = byte_idx_q;
        tx_valid_d  = tx_valid_q;
        tx_data_d   = tx_data_q;
        prev_ok_d   = prev_ok_q;

        // All channels run through the synchroniser; only the selected one is observed
        sync_d[0] = osc_in;
        for (int k = 1; k < SYNC_STAGES; k++) sync_d[k] = sync_q[k-1];
        sync_lvl_s = |(ch_onehot_s & sync_q[SYNC_STAGES-1]);
        prev_d     = sync_lvl_s;
        // prev_ok_q masks the first sample so a high level at enable is not an edge
        osc_rise_s = prev_ok_q & sync_lvl_s & ~prev_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    case (cmd_data[7:6])
                        2'b00: begin
                            ch_d    = cmd_data[5:0];
                            state_d = S_DECODE;
                        end
                        2'b01: begin
                            if ({3'b000, cmd_data[4:0]} > 8'(GATE_MAX_LOG2)) gate_log2_d = 5'(GATE_MAX_LOG2);
                            else                                             gate_log2_d = cmd_data[4:0];
                        end
                        default: begin
                            state_d = S_IDLE;
                        end
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DECODE: begin
                timer_d    = '0;
                count_d    = '0;
                prev_ok_d  = 1'b0;
                byte_idx_d = 8'd0;
                gate_len_d = TMR_W'(1) << gate_log2_q;
                bad_ch_d   = bad_ch_s;
                if (bad_ch_s) begin
                    state_d    = S_SEND;
                    tx_valid_d = 1'b1;
                    tx_data_d  = stream_byte(8'd0, count_q, 1'b1);
                end else begin
                    state_d = S_ENABLE;
                end
            end
            S_ENABLE: begin
                prev_ok_d = 1'b1;
                count_d   = '0;
                if (timer_q == TMR_W'((1 << SETTLE_LOG2) - 1)) begin
                    timer_d = '0;
                    state_d = S_GATE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_GATE: begin
                if (osc_rise_s && (count_q != {CNT_W{1'b1}})) count_d = count_q + CNT_W'(1);
                else                                          count_d = count_q;
                if (timer_q == gate_len_q - TMR_W'(1)) begin
                    timer_d    = '0;
                    state_d    = S_SEND;
                    byte_idx_d = 8'd0;
                    tx_valid_d = 1'b1;
                    tx_data_d  = stream_byte(8'd0, count_d, 1'b0);
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_SEND: begin
                if (tx_valid_q && tx_ready) begin
                    if (byte_idx_q == 8'(RESP_N - 1)) begin
                        state_d    = S_IDLE;
                        tx_valid_d = 1'b0;
                        tx_data_d  = 8'h00;
                        byte_idx_d = 8'd0;
                    end else begin
                        byte_idx_d = byte_idx_q + 8'd1;
                        tx_data_d  = stream_byte(byte_idx_q + 8'd1, count_q, bad_ch_q);
                    end
                end else begin
                    tx_valid_d = tx_valid_q;
                end
            end
            default: begin
                state_d    = S_IDLE;
                tx_valid_d = 1'b0;
            end
        endcase

        if (state_d == S_ENABLE || state_d == S_GATE) osc_en_d = ch_onehot_s;
        else                                          osc_en_d = '0;
        busy_d      = (state_d != S_IDLE);
        cmd_ready_d = (state_d == S_IDLE);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            ch_q        <= 6'd0;
            bad_ch_q    <= 1'b0;
            gate_log2_q <= 5'(DEFAULT_GATE_LOG2);
            gate_len_q  <= '0;
            timer_q     <= '0;
            count_q     <= '0;
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
            prev_q      <= 1'b0;
            prev_ok_q   <= 1'b0;
            byte_idx_q  <= 8'd0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            osc_en_q    <= '0;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            bad_ch_q    <= bad_ch_d;
            gate_log2_q <= gate_log2_d;
            gate_len_q  <= gate_len_d;
            timer_q     <= timer_d;
            count_q     <= count_d;
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= sync_d[k];
            prev_q      <= prev_d;
            prev_ok_q   <= prev_ok_d;
            byte_idx_q  <= byte_idx_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
            osc_en_q    <= osc_en_d;
            busy_q      <= busy_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    assign osc_en    = osc_en_q;
    assign tx_valid  = tx_valid_q;
    assign tx_data   = tx_data_q;
    assign busy      = busy_q;
    assign cmd_ready = cmd_ready_q;

endmodule

// File: tb/tb_ro_multi_freq_meter.sv
// Testbench for ro_multi_freq_meter: table of directed commands with
// hand-computed responses, plus sequences for backpressure, reset and saturation.
module tb_ro_multi_freq_meter;

`ifdef RO_METER_CHECKSUM_EN
    localparam int RN  = 4;
    localparam int RN8 = 2;
`else
    localparam int RN  = 3;
    localparam int RN8 = 1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       osc_a, osc_b, osc_c;
    logic [3:0] osc_in, osc_in8;
    logic [3:0] osc_en, osc_en8;
    logic       cmd_valid, cmd_ready, tx_valid, tx_ready, busy;
    logic [7:0] cmd_data, tx_data;
    logic       cmd_valid8, cmd_ready8, tx_valid8, tx_ready8, busy8;
    logic [7:0] cmd_data8, tx_data8;

    // Oscillators: clk/10, clk/4, clk/3, phase-offset so they never toggle on a clk edge
    initial begin osc_a = 1'b0; #3; forever #50 osc_a = ~osc_a; end
    initial begin osc_b = 1'b0; #3; forever #20 osc_b = ~osc_b; end
    initial begin osc_c = 1'b0; #3; forever #15 osc_c = ~osc_c; end
    assign osc_in  = {1'b0, osc_c, osc_b, osc_a};
    assign osc_in8 = {3'b000, osc_c};

    ro_multi_freq_meter dut (
        .clk(clk), .reset_n(reset_n), .osc_in(osc_in), .osc_en(osc_en),
        .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .busy(busy)
    );

    ro_multi_freq_meter #(.CNT_W(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .osc_in(osc_in8), .osc_en(osc_en8),
        .cmd_valid(cmd_valid8), .cmd_data(cmd_data8), .cmd_ready(cmd_ready8),
        .tx_valid(tx_valid8), .tx_data(tx_data8), .tx_ready(tx_ready8), .busy(busy8)
    );

    typedef struct {
        logic [7:0] cmd;
        int         kind;     // 0: no response, 1: measure, 2: invalid channel
        int         exp_cnt;
        int         tol;
        logic [3:0] exp_en;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];
    int   total = 0;
    int   bad = 0;
    int   model_gate = 10;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d..%0d", nm, act, lo, hi);
        end
    endtask

    task automatic send_cmd(input logic [7:0] c);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_data  = c;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic do_vec(input vec_t v, input string nm);
        int k, lat, j, val;
        logic [3:0] en1;
        logic [7:0] b [RN];
        chk({nm, "_rdy"}, int'(cmd_ready), 1);
        send_cmd(v.cmd);
        if (v.kind == 0) begin
            if (v.cmd[7:6] == 2'b01) model_gate = (int'(v.cmd[4:0]) > 20) ? 20 : int'(v.cmd[4:0]);
            k = 0;
            repeat (40) begin
                if (tx_valid === 1'b1 || busy === 1'b1) k++;
                @(negedge clk);
            end
            chk({nm, "_quiet"}, k, 0);
        end else begin
            chk({nm, "_busy"}, int'(busy), 1);
            lat = (v.kind == 2) ? 1 : (1 + 16 + (1 << model_gate));
            k = 0;
            en1 = 4'd0;
            do begin
                @(negedge clk);
                k++;
                if (k == 1) en1 = osc_en;
            end while (tx_valid !== 1'b1 && k < lat + 50);
            chk({nm, "_lat"}, k, lat);
            chk({nm, "_en"}, int'(en1), int'(v.exp_en));
            chk({nm, "_en_off"}, int'(osc_en), 0);
            for (int i = 0; i < RN; i++) begin
                j = 0;
                while (tx_valid !== 1'b1 && j < 10) begin @(negedge clk); j++; end
                b[i] = tx_data;
                @(negedge clk);
            end
            chk({nm, "_idle"}, int'({busy, tx_valid, cmd_ready}), 1);
            if (v.kind == 2) begin
                for (int i = 0; i < 3; i++) chk($sformatf("%s_ff%0d", nm, i), int'(b[i]), 255);
            end else begin
                val = int'({b[0], b[1], b[2]});
                chk({nm, "_top"}, int'(b[0]), 0);
                chk_rng({nm, "_cnt"}, val, v.exp_cnt - v.tol, v.exp_cnt + v.tol);
            end
`ifdef RO_METER_CHECKSUM_EN
            chk({nm, "_csum"}, int'(b[3]), int'(b[0] ^ b[1] ^ b[2]));
`endif
        end
    endtask

    initial begin
        int k, chg;
        logic [7:0] held;
        logic [7:0] rb;
        vecs[0]  = '{8'h00, 1, 102, 1, 4'b0001};
        vecs[1]  = '{8'h48, 0, 0, 0, 4'b0000};
        vecs[2]  = '{8'h01, 1, 64, 1, 4'b0010};
        vecs[3]  = '{8'h05, 2, 0, 0, 4'b0000};
        vecs[4]  = '{8'h44, 0, 0, 0, 4'b0000};
        vecs[5]  = '{8'h02, 1, 5, 1, 4'b0100};
        vecs[6]  = '{8'h03, 1, 0, 0, 4'b1000};
        vecs[7]  = '{8'h80, 0, 0, 0, 4'b0000};
        vecs[8]  = '{8'h40, 0, 0, 0, 4'b0000};
        vecs[9]  = '{8'h03, 1, 0, 0, 4'b1000};
        vecs[10] = '{8'h3F, 2, 0, 0, 4'b0000};
        vecs[11] = '{8'h44, 0, 0, 0, 4'b0000};

        cmd_valid = 1'b0; cmd_data = 8'h00; tx_ready = 1'b1;
        cmd_valid8 = 1'b0; cmd_data8 = 8'h00; tx_ready8 = 1'b1;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        chk("rst_osc_en", int'(osc_en), 0);
        chk("rst_tx", int'({tx_valid, tx_data}), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_rdy", int'(cmd_ready), 1);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < NV; i++) do_vec(vecs[i], $sformatf("v%0d", i));

        // Backpressure: tx_ready low for 50 cycles, command pulsed meanwhile
        tx_ready = 1'b0;
        send_cmd(8'h03);
        k = 0;
        while (tx_valid !== 1'b1 && k < 200) begin @(negedge clk); k++; end
        chk("hold_lat", k, 33);
        held = tx_data;
        chg = 0;
        for (int i = 0; i < 50; i++) begin
            if (i == 20) begin
                cmd_valid = 1'b1;
                cmd_data  = 8'h4F;
                chk("hold_cmd_rdy", int'(cmd_ready), 0);
            end
            if (i == 21) cmd_valid = 1'b0;
            @(negedge clk);
            if (tx_valid !== 1'b1 || tx_data !== held) chg++;
        end
        chk("hold_stable", chg, 0);
        chk("hold_byte0", int'(held), 0);
        tx_ready = 1'b1;
        chg = 0;
        for (int i = 0; i < RN; i++) begin
            k = 0;
            while (tx_valid !== 1'b1 && k < 10) begin @(negedge clk); k++; end
            if (tx_valid !== 1'b1 || tx_data !== 8'h00) chg++;
            @(negedge clk);
        end
        chk("hold_bytes", chg, 0);
        chk("hold_idle", int'({busy, tx_valid, cmd_ready}), 1);
        // gate_log2 must still be 4: the 0x4F pulse was not accepted
        do_vec('{8'h03, 1, 0, 0, 4'b1000}, "post_hold");

        // Reset in the middle of a gate window
        send_cmd(8'h00);
        repeat (20) @(negedge clk);
        chk("mid_en", int'(osc_en), 1);
        #1 reset_n = 1'b0;
        #1;
        chk("mid_rst_en", int'(osc_en), 0);
        chk("mid_rst_tx", int'(tx_valid), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_rdy", int'(cmd_ready), 1);
        @(negedge clk);
        reset_n = 1'b1;
        model_gate = 10;
        do_vec('{8'h03, 1, 0, 0, 4'b1000}, "dflt");

        // CNT_W=8 instance: clk/3 over 1024 cycles saturates at 0xFF
        @(negedge clk);
        cmd_valid8 = 1'b1; cmd_data8 = 8'h00;
        @(posedge clk);
        @(negedge clk);
        cmd_valid8 = 1'b0;
        k = 0;
        do begin @(negedge clk); k++; end while (tx_valid8 !== 1'b1 && k < 1200);
        chk("sat_lat", k, 1041);
        for (int i = 0; i < RN8; i++) begin
            rb = tx_data8;
            chk($sformatf("sat_b%0d", i), int'({tx_valid8, rb}), 511);
            @(negedge clk);
        end
        chk("sat_idle", int'({busy8, tx_valid8, cmd_ready8}), 1);

        // Reset during GATE of the CNT_W=8 instance: no bytes afterwards
        @(negedge clk);
        cmd_valid8 = 1'b1; cmd_data8 = 8'h00;
        @(posedge clk);
        @(negedge clk);
        cmd_valid8 = 1'b0;
        repeat (600) @(negedge clk);
        chk("sat_gate_busy", int'(busy8), 1);
        #1 reset_n = 1'b0;
        #1;
        chk("sat_rst_busy", int'(busy8), 0);
        @(negedge clk);
        reset_n = 1'b1;
        k = 0;
        repeat (1100) begin
            @(negedge clk);
            if (tx_valid8 === 1'b1 || busy8 === 1'b1) k++;
        end
        chk("sat_rst_quiet", k, 0);
        chk("sat_rst_rdy", int'(cmd_ready8), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
